// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter.
// Width helpers are functions because index and count widths depend on each instance's parameters.
package mem_arb_pkg;

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Width of a port index; a single-entry range still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold every value from 0 up to and including max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

    function automatic int unsigned next_rr(input int unsigned sel, input int unsigned num_ports);
        return (sel + 1 >= num_ports) ? 0 : sel + 1;
    endfunction

endpackage

// File: rtl/mem_arb_idx_fifo.sv
// In-order FIFO of granted port indices; the head names the port owed the next response.
module mem_arb_idx_fifo
    import mem_arb_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 1,
    localparam int unsigned CntW = cnt_width(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = idx_width(Depth);
    typedef logic [PtrW-1:0] ptr_t;

    logic [Width-1:0] mem_q [Depth];
    ptr_t             wr_ptr_q;
    ptr_t             rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(Depth - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
        end
    end

    // NOTE: storage is not reset; an entry is only ever read after a push has written it.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/mem_to_banks_arbiter.sv
// Round-robin arbiter with request locking that shares one memory port among NumPorts requesters;
// responses are routed back in order through a FIFO of granted port indices.
module mem_to_banks_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NumPorts  = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned AtopWidth = 6,
    parameter int unsigned MaxTrans  = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NumPorts-1:0]                req_i,
    output logic [NumPorts-1:0]                gnt_o,
    input  logic [NumPorts*AddrWidth-1:0]      addr_i,
    input  logic [NumPorts*DataWidth-1:0]      wdata_i,
    input  logic [NumPorts*(DataWidth/8)-1:0]  strb_i,
    input  logic [NumPorts*AtopWidth-1:0]      atop_i,
    input  logic [NumPorts-1:0]                we_i,
    output logic [NumPorts-1:0]                rvalid_o,
    output logic [NumPorts*DataWidth-1:0]      rdata_o,
    output logic                               mem_req_o,
    input  logic                               mem_gnt_i,
    output logic [AddrWidth-1:0]               mem_addr_o,
    output logic [DataWidth-1:0]               mem_wdata_o,
    output logic [DataWidth/8-1:0]             mem_strb_o,
    output logic [AtopWidth-1:0]               mem_atop_o,
    output logic                               mem_we_o,
    input  logic                               mem_rvalid_i,
    input  logic [DataWidth-1:0]               mem_rdata_i,
    output logic                               idle_o
);

    localparam int unsigned IdxW      = idx_width(NumPorts);
    localparam int unsigned CntW      = cnt_width(MaxTrans);
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef logic [IdxW-1:0] idx_t;
    typedef logic [CntW-1:0] cnt_t;

    arb_state_e state_q, state_d;
    idx_t       rr_q, rr_d;
    idx_t       lock_idx_q, lock_idx_d;
    idx_t       sel;
    idx_t       cand;
    logic       found;
    logic       handshake;
    logic       rsp_pop;
    idx_t       fifo_head;
    cnt_t       fifo_count;
    logic       fifo_full;
    logic       fifo_empty;

    // NOTE: combinational blocks assign every output a default first, so no path can infer a latch.
    always_comb begin
        sel   = rr_q;
        cand  = '0;
        found = 1'b0;
        if (state_q == ARB_LOCKED) begin
            sel = lock_idx_q;
        end else begin
            for (int unsigned i = 0; i < NumPorts; i++) begin
                cand = idx_t'((32'(rr_q) + i) % NumPorts);
                if (!found && req_i[cand]) begin
                    sel   = cand;
                    found = 1'b1;
                end
            end
        end
    end

    // A full FIFO blocks new requests; a response frees its slot only from the next cycle on.
    assign mem_req_o   = req_i[sel] && !fifo_full;
    assign handshake   = mem_req_o && mem_gnt_i;
    assign mem_addr_o  = addr_i[sel*AddrWidth +: AddrWidth];
    assign mem_wdata_o = wdata_i[sel*DataWidth +: DataWidth];
    assign mem_strb_o  = strb_i[sel*StrbWidth +: StrbWidth];
    assign mem_atop_o  = atop_i[sel*AtopWidth +: AtopWidth];
    assign mem_we_o    = we_i[sel];

    assign rsp_pop = mem_rvalid_i && !fifo_empty;
    assign rdata_o = {NumPorts{mem_rdata_i}};
    assign idle_o  = (fifo_count == '0) && (state_q == ARB_FREE);

    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        gnt_o[sel] = handshake;
        if (rsp_pop) rvalid_o[fifo_head] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        lock_idx_d = lock_idx_q;
        if (handshake) begin
            state_d = ARB_FREE;
            rr_d    = idx_t'(next_rr(32'(sel), NumPorts));
        end else if (mem_req_o) begin
            state_d    = ARB_LOCKED;
            lock_idx_d = sel;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ARB_FREE;
            rr_q       <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    mem_arb_idx_fifo #(
        .Depth (MaxTrans),
        .Width (IdxW)
    ) u_idx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (handshake),
        .data_i  (sel),
        .pop_i   (rsp_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // A presented request that is not yet granted must hold its request and payload.
    a_lock_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == ARB_LOCKED) |-> (req_i[lock_idx_q] && $stable(mem_addr_o) &&
            $stable(mem_wdata_o) && $stable(mem_strb_o) && $stable(mem_atop_o) && $stable(mem_we_o)));

    a_rsp_expected: assert property (@(posedge clk_i) disable iff (rst_i)
        mem_rvalid_i |-> !fifo_empty);

endmodule

// File: tb/tb_mem_to_banks_arbiter.sv
// Randomized and directed bench for mem_to_banks_arbiter against a queue-based reference model.
module tb_mem_to_banks_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TW = 6;
    localparam int MT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [N-1:0]  req;
    logic [AW-1:0] p_addr  [N];
    logic [DW-1:0] p_wdata [N];
    logic [SW-1:0] p_strb  [N];
    logic [TW-1:0] p_atop  [N];
    logic [N-1:0]  p_we;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    logic [N*AW-1:0] addr_pk;
    logic [N*DW-1:0] wdata_pk;
    logic [N*SW-1:0] strb_pk;
    logic [N*TW-1:0] atop_pk;

    logic [N-1:0]    gnt_o;
    logic [N-1:0]    rvalid_o;
    logic [N*DW-1:0] rdata_o;
    logic            mem_req_o;
    logic [AW-1:0]   mem_addr_o;
    logic [DW-1:0]   mem_wdata_o;
    logic [SW-1:0]   mem_strb_o;
    logic [TW-1:0]   mem_atop_o;
    logic            mem_we_o;
    logic            idle_o;

    always_comb begin
        addr_pk  = '0;
        wdata_pk = '0;
        strb_pk  = '0;
        atop_pk  = '0;
        for (int p = 0; p < N; p++) begin
            addr_pk[p*AW +: AW]  = p_addr[p];
            wdata_pk[p*DW +: DW] = p_wdata[p];
            strb_pk[p*SW +: SW]  = p_strb[p];
            atop_pk[p*TW +: TW]  = p_atop[p];
        end
    end

    mem_to_banks_arbiter #(
        .NumPorts (N), .AddrWidth (AW), .DataWidth (DW), .AtopWidth (TW), .MaxTrans (MT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .gnt_o        (gnt_o),
        .addr_i       (addr_pk),
        .wdata_i      (wdata_pk),
        .strb_i       (strb_pk),
        .atop_i       (atop_pk),
        .we_i         (p_we),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_strb_o   (mem_strb_o),
        .mem_atop_o   (mem_atop_o),
        .mem_we_o     (mem_we_o),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .idle_o       (idle_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: arbitration pointer, lock holder, outstanding port queue, response due times.
    int m_rr;
    int m_lock;
    int oq[$];
    int due_q[$];
    int cyc;
    int rsp_lat;
    logic [N-1:0] pending;

    bit           e_req, e_hs, e_pop;
    int           e_sel;
    logic [N-1:0] e_gnt, e_rv;

    task automatic eval();
        bit full;
        #1;
        full  = (oq.size() == MT);
        e_sel = -1;
        if (m_lock >= 0) e_sel = m_lock;
        else
            for (int i = 0; i < N; i++)
                if (e_sel < 0 && req[(m_rr + i) % N]) e_sel = (m_rr + i) % N;
        e_req = 1'b0;
        if (e_sel >= 0) e_req = req[e_sel] && !full;
        e_hs  = e_req && mem_gnt;
        e_gnt = '0;
        if (e_hs) e_gnt[e_sel] = 1'b1;
        e_pop = mem_rvalid && (oq.size() > 0);
        e_rv  = '0;
        if (e_pop) e_rv[oq[0]] = 1'b1;

        check("mem_req", mem_req_o, e_req);
        check("gnt", gnt_o, e_gnt);
        if (e_req) begin
            check("mem_addr", mem_addr_o, p_addr[e_sel]);
            check("mem_wdata", mem_wdata_o, p_wdata[e_sel]);
            check("mem_strb", mem_strb_o, p_strb[e_sel]);
            check("mem_atop", mem_atop_o, p_atop[e_sel]);
            check("mem_we", mem_we_o, p_we[e_sel]);
        end
        check("rvalid", rvalid_o, e_rv);
        if (e_pop) check("rdata", rdata_o[oq[0]*DW +: DW], mem_rdata);
        check("idle", idle_o, (oq.size() == 0) && (m_lock < 0));
    endtask

    task automatic advance();
        if (rst) begin
            m_rr   = 0;
            m_lock = -1;
            oq.delete();
            due_q.delete();
        end else begin
            if (e_pop) begin
                void'(oq.pop_front());
                void'(due_q.pop_front());
            end
            if (e_hs) begin
                m_lock = -1;
                m_rr   = (e_sel + 1) % N;
                oq.push_back(e_sel);
                due_q.push_back(cyc + rsp_lat);
            end else if (e_req) begin
                m_lock = e_sel;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive_rsp(input int pct);
        mem_rvalid = 1'b0;
        if (due_q.size() > 0 && due_q[0] <= cyc && $urandom_range(0, 99) < pct) begin
            mem_rvalid = 1'b1;
            mem_rdata  = DW'($urandom);
        end
    endtask

    task automatic drive_ports(input int pct);
        for (int p = 0; p < N; p++) begin
            if (!pending[p] && $urandom_range(0, 99) < pct) begin
                pending[p]  = 1'b1;
                p_addr[p]   = AW'($urandom);
                p_wdata[p]  = DW'($urandom);
                p_strb[p]   = SW'($urandom);
                p_atop[p]   = TW'($urandom);
                p_we[p]     = 1'($urandom);
            end
        end
        req = pending;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; pending = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        eval();
        advance();
        rst = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        req = '0;
        for (int k = 0; k < n; k++) begin
            drive_rsp(100);
            eval();
            advance();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t reached, bench expected to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_grants;
        rst = 1'b1; req = '0; pending = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = '0; rsp_lat = 1; cyc = 0; m_rr = 0; m_lock = -1;
        for (int p = 0; p < N; p++) begin
            p_addr[p] = AW'(16'h0100 * (p + 1)); p_wdata[p] = DW'(p); p_strb[p] = '1;
            p_atop[p] = '0; p_we[p] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state: nothing requested, only idle asserted.
        eval();
        check("rst_gnt", gnt_o, 0);
        check("rst_idle", idle_o, 1);
        advance();

        // Two ports held with immediate grant and one-cycle responses: strict alternation.
        req = 3'b011; mem_gnt = 1'b1; rsp_lat = 1;
        for (int k = 0; k < 6; k++) begin
            drive_rsp(100);
            eval();
            check("alt_gnt", gnt_o, (k % 2 == 0) ? 3'b001 : 3'b010);
            if (k > 0) check("alt_rvalid", rvalid_o, (k % 2 == 1) ? 3'b001 : 3'b010);
            advance();
        end
        idle_cycles(3);

        // P1 stalls three cycles while P0 joins; the lock keeps P1 selected.
        do_reset();
        p_addr[0] = 16'h1000; p_addr[1] = 16'h2222; req = 3'b010;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) req[0] = 1'b1;
            if (k == 4) req[1] = 1'b0;
            mem_gnt = (k >= 3);
            drive_rsp(100);
            eval();
            if (k < 3) check("lock_addr", mem_addr_o, 16'h2222);
            if (k == 3) check("lock_gnt_p1", gnt_o, 3'b010);
            if (k == 4) check("lock_gnt_p0", gnt_o, 3'b001);
            advance();
        end
        idle_cycles(3);

        // No responses: exactly MaxTrans grants, and a freed slot is usable only a cycle later.
        do_reset();
        req = 3'b111; mem_gnt = 1'b1; n_grants = 0;
        for (int k = 0; k < 8; k++) begin
            mem_rvalid = (k == 5);
            mem_rdata  = 32'hCAFE_0001;
            eval();
            if (k < 5 && gnt_o != '0) n_grants++;
            if (k == 4) check("full_no_req", mem_req_o, 0);
            if (k == 5) check("full_rsp_no_gnt", gnt_o, 0);
            if (k == 6) check("freed_slot_gnt", gnt_o, 3'b010);
            advance();
        end
        check("full_grants", n_grants, MT);
        idle_cycles(8);

        // Reset with transactions outstanding; a stray response afterwards is dropped.
        do_reset();
        req = 3'b011; mem_gnt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mem_rvalid = 1'b0;
            eval();
            advance();
        end
        rst = 1'b1; req = '0; mem_gnt = 1'b0;
        eval();
        check("pre_rst_idle", idle_o, 0);
        advance();
        mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        eval();
        check("rst_idle_next", idle_o, 1);
        check("stray_rvalid", rvalid_o, 0);
        advance();
        rst = 1'b0; mem_rvalid = 1'b0; req = 3'b011; mem_gnt = 1'b1;
        eval();
        check("rr_restart", gnt_o, 3'b001);
        advance();
        idle_cycles(3);

        // Randomized traffic: sticky requests, random grants, random in-order response latency.
        for (int c = 0; c < 3000; c++) begin
            drive_ports(50);
            mem_gnt = ($urandom_range(0, 99) < 70);
            rsp_lat = $urandom_range(1, 5);
            drive_rsp(75);
            eval();
            if (e_hs) pending[e_sel] = 1'b0;
            advance();
        end

        // Drain every pending request and response.
        for (int c = 0; c < 300 && (pending != '0 || oq.size() != 0); c++) begin
            drive_ports(0);
            mem_gnt = 1'b1;
            rsp_lat = 1;
            drive_rsp(100);
            eval();
            if (e_hs) pending[e_sel] = 1'b0;
            advance();
        end
        check("drain_outstanding", oq.size(), 0);
        check("drain_pending", pending, 0);
        req = '0; mem_rvalid = 1'b0;
        eval();
        check("final_idle", idle_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
